// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
// Used by apb_rr_picker and apb_req_arbiter (optional timeout: APB_ARB_TIMEOUT_EN).
package apb_arb_pkg;

  // Sequencer states; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Read data returned when a transfer is abandoned after the timeout.
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: scans last_grant+1 .. last_grant
// (wrapping modulo NUM_REQ) and returns the first requesting index.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  // One extra bit so last_grant + k (at most 2*NUM_REQ-1) never overflows.
  localparam int SW = IDX_W + 1;

  logic [SW-1:0] cand;

  // Rotating priority scan; the first hit after the last winner takes the grant.
  always_comb begin
    any_o    = 1'b0;
    winner_o = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_i} + SW'(k);
      if (cand >= SW'(NUM_REQ)) begin
        cand = cand - SW'(NUM_REQ);
      end
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o    = 1'b1;
        winner_o = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sequencer sharing one apb_master between NUM_REQ clients.
// One transfer outstanding at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Optional WAIT timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
//
// Handshake: a client raises req with a stable payload and keeps it until it
// sees its ack bit (one cycle). m_valid is a single-cycle command strobe to the
// master; the master answers with a one-cycle m_ready, and its registered
// m_rdata is valid the cycle after m_ready. ack follows two cycles after m_ready.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int PSEL_LSB    = 28,
  parameter  int TIMEOUT_CYC = 256,
  localparam int IDX_W       = idx_w(NUM_REQ)
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*2-1:0]      req_strb,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      busy,
  output logic                      m_valid,
  output logic [1:0]                m_psel,
  output logic                      m_write,
  output logic [ADDR_W-1:0]         m_addr,
  output logic [DATA_W-1:0]         m_wdata,
  output logic [1:0]                m_strb,
  input  logic                      m_ready,
  input  logic [DATA_W-1:0]         m_rdata
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || PSEL_LSB + 2 > ADDR_W || TIMEOUT_CYC < 1) begin : g_param_err
    $error("apb_req_arbiter: illegal parameter combination");
  end

  // Registered state and outputs.
  arb_state_e           state_q;
  logic [IDX_W-1:0]     last_grant_q;
  logic [IDX_W-1:0]     grant_id_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  logic                 m_valid_q;
  logic                 m_write_q;
  logic [ADDR_W-1:0]    m_addr_q;
  logic [DATA_W-1:0]    m_wdata_q;
  logic [1:0]           m_strb_q;

  // Per-client views of the packed payload buses.
  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];
  logic [1:0]           strb_arr  [NUM_REQ];

  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]     wait_cnt_q;
  logic                 timed_out_q;
  logic                 rsp_err_q;
`endif

  // Unpack the client payload buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      strb_arr[i]  = req_strb[i*2 +: 2];
    end
  end

  apb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx)
  );

  // Sequencer: grant, issue one command strobe, wait for completion, acknowledge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      ack_q        <= '0;
      rsp_rdata_q  <= '0;
      m_valid_q    <= 1'b0;
      m_write_q    <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_strb_q     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timed_out_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      // ack and rsp_err are single-cycle pulses unless DONE sets them below.
      ack_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      rsp_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q    <= ISSUE;
            m_valid_q  <= 1'b1;
            grant_id_q <= pick_idx;
            m_write_q  <= req_write[pick_idx];
            m_addr_q   <= addr_arr[pick_idx];
            m_wdata_q  <= wdata_arr[pick_idx];
            m_strb_q   <= strb_arr[pick_idx];
          end
        end
        ISSUE: begin
          state_q   <= WAIT;
          m_valid_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt_q  <= '0;
          timed_out_q <= 1'b0;
`endif
        end
        WAIT: begin
          if (m_ready) begin
            state_q <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_q     <= DONE;
            timed_out_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          // The master's prdata is registered, so it is sampled here, one cycle after m_ready.
          state_q             <= IDLE;
          ack_q[grant_id_q]   <= 1'b1;
          last_grant_q        <= grant_id_q;
`ifdef APB_ARB_TIMEOUT_EN
          rsp_err_q   <= timed_out_q;
          rsp_rdata_q <= timed_out_q ? DATA_W'(DEADBEEF) : m_rdata;
`else
          rsp_rdata_q <= m_rdata;
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rsp_rdata_q;
  assign grant_id  = grant_id_q;
  assign busy      = (state_q != IDLE);
  assign m_valid   = m_valid_q;
  assign m_write   = m_write_q;
  assign m_addr    = m_addr_q;
  assign m_psel    = m_addr_q[PSEL_LSB +: 2];
  assign m_wdata   = m_wdata_q;
  assign m_strb    = m_strb_q;

`ifdef APB_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed cases plus randomized
// request patterns scored against a transaction-level round-robin model.
// The timeout case is included when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*2-1:0]  req_strb;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [1:0]      grant_id;
  logic            busy;
  logic            m_valid;
  logic [1:0]      m_psel;
  logic            m_write;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [1:0]      m_strb;
  logic            m_ready;
  logic [DW-1:0]   m_rdata;

  // Client payloads, packed onto the request buses.
  logic [AW-1:0] cl_addr  [N];
  logic [DW-1:0] cl_wdata [N];
  logic [1:0]    cl_strb  [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = cl_addr[i];
      req_wdata[i*DW +: DW] = cl_wdata[i];
      req_strb[i*2 +: 2]    = cl_strb[i];
    end
  end

  apb_req_arbiter #(
    .NUM_REQ     (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .PSEL_LSB    (28),
    .TIMEOUT_CYC (16)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .grant_id  (grant_id),
    .busy      (busy),
    .m_valid   (m_valid),
    .m_psel    (m_psel),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_strb    (m_strb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int last_g   = N - 1;   // model of the round-robin pointer

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Round-robin rule: first requester after the last winner, wrapping.
  function automatic int model_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // All sampling and driving happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_client(input int c, input bit wr);
    cl_addr[c]   = $urandom;
    cl_wdata[c]  = $urandom;
    cl_strb[c]   = 2'($urandom_range(0, 3));
    req_write[c] = wr;
  endtask

  // ---------------- driver: one complete transfer ----------------
  // Called in a cycle where the DUT is idle and req is nonzero. Returns at
  // the cycle ack is visible; the winning client drops req there if drop=1.
  task automatic xfer(input int delay, input bit drop, input logic [DW-1:0] rd, output int got);
    int w;
    logic [AW-1:0] ea;
    w   = model_pick(req, last_g);
    got = w;
    ea  = cl_addr[w];
    step();
    check("issue_valid", m_valid, 1);
    if (m_valid !== 1'b1) return;
    check("grant_id", grant_id, w);
    check("busy_issue", busy, 1);
    check("m_write", m_write, req_write[w]);
    check("m_addr", m_addr, ea);
    check("m_psel", m_psel, ea[29:28]);
    check("m_wdata", m_wdata, cl_wdata[w]);
    check("m_strb", m_strb, cl_strb[w]);
    step();
    check("valid_one_cycle", m_valid, 0);
    for (int i = 0; i < delay; i++) begin
      step();
      check("wait_no_ack", ack, 0);
      check("wait_addr_stable", m_addr, ea);
      check("wait_valid_low", m_valid, 0);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    m_rdata = rd;
    check("done_no_ack", ack, 0);
    step();
    m_rdata = $urandom;
    check("ack_onehot", ack, N'(1) << w);
    check("rsp_err", rsp_err, 0);
    check("busy_after", busy, 0);
    if (!req_write[w]) check("rsp_rdata", rsp_rdata, rd);
    last_g = w;
    if (drop) req[w] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got;
    int mode;
    int cnt;
    presetn   = 1'b0;
    req       = '0;
    req_write = '0;
    m_ready   = 1'b0;
    m_rdata   = '0;
    for (int i = 0; i < N; i++) begin
      cl_addr[i]  = '0;
      cl_wdata[i] = '0;
      cl_strb[i]  = '0;
    end
    step(); step();
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", m_valid, 0);
    check("rst_addr", m_addr, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_grant", grant_id, 0);
    presetn = 1'b1;
    step();

    // Fairness: all four held for eight transfers.
    for (int c = 0; c < N; c++) set_client(c, 1'($urandom_range(0, 1)));
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      xfer(1, 1'b0, $urandom, got);
      check("fair_order", got, i % N);
    end
    req = '0;
    step();

    // Single write from client 2.
    cl_addr[2] = 32'h1000_0040; cl_wdata[2] = 32'hA5A5_0001; cl_strb[2] = 2'b11;
    req_write[2] = 1'b1;
    req = 4'b0100;
    xfer(2, 1'b1, $urandom, got);
    check("write_psel", cl_addr[2][29:28], 2'b01);
    check("write_client", got, 2);

    // Read from client 1 with fixed return data.
    set_client(1, 1'b0);
    req = 4'b0010;
    xfer(0, 1'b1, 32'h1234_5678, got);
    check("read_rdata", rsp_rdata, 32'h1234_5678);

    // Single requester held: re-granted every 4 cycles.
    set_client(3, 1'b0);
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cnt = $time;
      xfer(0, 1'b0, $urandom, got);
      check("single_period", ($time - cnt) / 10, 4);
    end
    req = '0;
    step();

    // Back-pressure: 50 cycles of m_ready low on client 0.
    set_client(0, 1'b1);
    req = 4'b0001;
    xfer(50, 1'b1, $urandom, got);
    check("bp_client", got, 0);

    // Reset in the middle of WAIT aborts the transfer.
    set_client(1, 1'b0);
    req = 4'b0010;
    step();
    check("rstw_valid", m_valid, 1);
    step(); step(); step();
    presetn = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_valid0", m_valid, 0);
    check("rstw_ack", ack, 0);
    check("rstw_addr", m_addr, 0);
    check("rstw_grant", grant_id, 0);
    req    = '0;
    last_g = N - 1;
    step();
    check("rstw_hold_ack", ack, 0);
    presetn = 1'b1;
    step();
    set_client(0, 1'b0); set_client(1, 1'b1); set_client(3, 1'b0);
    req = 4'b1011;
    xfer(1, 1'b1, $urandom, got);
    check("post_rst_client0", got, 0);
    while (req != '0) xfer($urandom_range(0, 3), 1'b1, $urandom, got);
    step();

    // Randomized request patterns against the model.
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < N; c++) set_client(c, 1'($urandom_range(0, 1)));
      req  = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 1);
      if (mode == 0) begin
        while (req != '0) xfer($urandom_range(0, 6), 1'b1, $urandom, got);
      end else begin
        for (int j = 0; j < 5; j++) xfer($urandom_range(0, 4), 1'b0, $urandom, got);
        req = '0;
      end
      for (int k = 0; k < $urandom_range(0, 2); k++) step();
      check("idle_between", busy, 0);
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout: m_ready never asserts.
    set_client(2, 1'b0);
    req = 4'b0100;
    step();
    check("to_valid", m_valid, 1);
    step();
    for (int j = 1; j <= 16; j++) begin
      step();
      check("to_no_ack", ack, 0);
    end
    step();
    check("to_ack", ack, 4'b0100);
    check("to_err", rsp_err, 1);
    check("to_rdata", rsp_rdata, 32'hDEAD_BEEF);
    req = '0;
    step();
    check("to_err_pulse", rsp_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
